// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue unit: drives the synchronous instruction RAM, latches the
// returned word into the IR and resolves JUMPZ/JUMPNZ/HALT flow control on handshake.
//
// state | meaning
// IDLE  | waiting for start after reset
// ISSUE | ram_addr=pc presented, RAM samples it on this edge
// WAIT  | ram_data valid, latched into the IR on this edge
// HOLD  | IR valid, waiting for ir_ready handshake
// HALT  | OP_HALT accepted, fetch stopped until start
module instr_fetch_unit #(
    parameter int          ADDR_W    = 8,
    parameter logic [5:0]  OP_JUMPNZ = 6'd47,
    parameter logic [5:0]  OP_JUMPZ  = 6'd52,
    parameter logic [5:0]  OP_HALT   = 6'd46
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_data,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [5:0]        ir_opcode,
    output logic [9:0]        ir_operand,
    input  logic              z_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t state;

    logic jump_taken;
    assign jump_taken = ((ir_opcode == OP_JUMPZ)  &&  z_flag) ||
                        ((ir_opcode == OP_JUMPNZ) && !z_flag);

    assign ram_addr = pc;
    assign busy     = (state == ISSUE) || (state == WAIT) || (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            ir_valid   <= 1'b0;
            ir_opcode  <= '0;
            ir_operand <= '0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    ir_opcode  <= ram_data[15:10];
                    ir_operand <= ram_data[9:0];
                    ir_valid   <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (ir_opcode == OP_HALT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            // jump targets beyond the address space wrap by truncation
                            pc    <= jump_taken ? ir_operand[ADDR_W-1:0] : pc + ADDR_W'(1);
                            state <= ISSUE;
                        end
                    end
                end
                HALT: begin
                    if (start) begin
                        halted     <= 1'b0;
                        pc         <= '0;
                        ir_opcode  <= '0;
                        ir_operand <= '0;
                        state      <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a behavioural
// one-cycle-latency instruction RAM.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [5:0]  ir_opcode;
    logic [9:0]  ir_operand;
    logic        z_flag;
    logic [7:0]  pc;
    logic        halted;
    logic        busy;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .z_flag     (z_flag),
        .pc         (pc),
        .halted     (halted),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= mem[ram_addr];

    typedef struct {
        logic [7:0] pc;
        logic [5:0] op;
        logic [9:0] opd;
        logic       z;
        int         stall;
        logic [7:0] next;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ir_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ir_valid_timeout", 32'(ir_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = {6'd2,  10'd0};
        mem[1]   = {6'd47, 10'd255};
        mem[255] = {6'd3,  10'd5};
        mem[2]   = {6'd52, 10'd142};
        mem[142] = {6'd52, 10'd159};
        mem[159] = {6'd47, 10'd654};
        mem[143] = {6'd47, 10'd162};
        mem[162] = {6'd47, 10'd63};
        mem[63]  = {6'd47, 10'd162};
        mem[163] = {6'd46, 10'd0};

        vecs[0]  = '{8'd0,   6'd2,  10'd0,   1'b0, 10, 8'd1};
        vecs[1]  = '{8'd1,   6'd47, 10'd255, 1'b0, 0,  8'd255};
        vecs[2]  = '{8'd255, 6'd3,  10'd5,   1'b0, 0,  8'd0};
        vecs[3]  = '{8'd0,   6'd2,  10'd0,   1'b1, 0,  8'd1};
        vecs[4]  = '{8'd1,   6'd47, 10'd255, 1'b1, 0,  8'd2};
        vecs[5]  = '{8'd2,   6'd52, 10'd142, 1'b1, 0,  8'd142};
        vecs[6]  = '{8'd142, 6'd52, 10'd159, 1'b1, 0,  8'd159};
        vecs[7]  = '{8'd159, 6'd47, 10'd654, 1'b0, 0,  8'd142};
        vecs[8]  = '{8'd142, 6'd52, 10'd159, 1'b0, 3,  8'd143};
        vecs[9]  = '{8'd143, 6'd47, 10'd162, 1'b0, 0,  8'd162};
        vecs[10] = '{8'd162, 6'd47, 10'd63,  1'b0, 0,  8'd63};
        vecs[11] = '{8'd63,  6'd47, 10'd162, 1'b0, 0,  8'd162};
        vecs[12] = '{8'd162, 6'd47, 10'd63,  1'b1, 0,  8'd163};

        rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; z_flag = 1'b0;
        #12;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // start sampled at E0; ir_valid must appear only after E2
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_ram_addr", 32'(ram_addr), 32'd0);
        check("issue_ir_valid", 32'(ir_valid), 32'd0);
        @(negedge clk);
        check("wait_ir_valid", 32'(ir_valid), 32'd0);
        @(negedge clk);
        check("hold_ir_valid", 32'(ir_valid), 32'd1);
        check("hold_opcode", 32'(ir_opcode), 32'd2);

        for (int i = 0; i < 13; i++) begin
            wait_valid();
            check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
            check($sformatf("v%0d_opcode", i), 32'(ir_opcode), 32'(vecs[i].op));
            check($sformatf("v%0d_operand", i), 32'(ir_operand), 32'(vecs[i].opd));
            z_flag = ~vecs[i].z;
            for (int s = 0; s < vecs[i].stall; s++) begin
                @(negedge clk);
                check($sformatf("v%0d_stall_valid", i), 32'(ir_valid), 32'd1);
                check($sformatf("v%0d_stall_pc", i), 32'(pc), 32'(vecs[i].pc));
                check($sformatf("v%0d_stall_addr", i), 32'(ram_addr), 32'(vecs[i].pc));
                check($sformatf("v%0d_stall_ir", i), 32'({ir_opcode, ir_operand}),
                      32'({vecs[i].op, vecs[i].opd}));
            end
            z_flag = vecs[i].z;
            ir_ready = 1'b1;
            @(negedge clk);
            ir_ready = 1'b0;
            z_flag = ~vecs[i].z;
            check($sformatf("v%0d_accept_valid", i), 32'(ir_valid), 32'd0);
            check($sformatf("v%0d_next_addr", i), 32'(ram_addr), 32'(vecs[i].next));
        end

        wait_valid();
        check("halt_pc", 32'(pc), 32'd163);
        check("halt_opcode", 32'(ir_opcode), 32'd46);
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_valid", 32'(ir_valid), 32'd0);
        repeat (5) @(negedge clk);
        check("halt_hold_pc", 32'(pc), 32'd163);
        check("halt_hold_addr", 32'(ram_addr), 32'd163);
        check("halt_hold_valid", 32'(ir_valid), 32'd0);

        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_addr", 32'(ram_addr), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_ir", 32'({ir_opcode, ir_operand}), 32'd0);

        // now in WAIT: reset must take effect without a clock edge
        @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_valid", 32'(ir_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ir", 32'({ir_opcode, ir_operand}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_valid", 32'(ir_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_addr", 32'(ram_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
